// File: rtl/falafel_pkg.sv
// Shared falafel widths and constants.
package falafel_pkg;
  parameter int unsigned DATA_W = 32;
  parameter logic [DATA_W-1:0] EMPTY_KEY = '0;
endpackage

// File: rtl/falafel_mem_responder.sv
// Single-outstanding memory responder. It services load, store and CAS requests
// against a word array and returns the result after a fixed latency.
module falafel_mem_responder #(
  parameter int unsigned       DATA_W  = falafel_pkg::DATA_W,
  parameter int unsigned       DEPTH   = 1024,
  parameter int unsigned       LATENCY = 2,
  parameter logic [DATA_W-1:0] CAS_EXP = falafel_pkg::EMPTY_KEY
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              mem_req_val_i,
  output logic              mem_req_rdy_o,
  input  logic              mem_req_is_write_i,
  input  logic              mem_req_is_cas_i,
  input  logic [DATA_W-1:0] mem_req_addr_i,
  input  logic [DATA_W-1:0] mem_req_data_i,
  output logic              mem_rsp_val_o,
  input  logic              mem_rsp_rdy_i,
  output logic [DATA_W-1:0] mem_rsp_data_o,
  output logic [31:0]       cas_fail_cnt_o
);

  localparam int unsigned OFS   = $clog2(DATA_W / 8);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e            r_state, w_state_next;
  logic [7:0]        r_cnt;
  logic              r_op_cas, r_op_wr;
  logic [DATA_W-1:0] r_addr, r_data, r_rsp_data;
  logic [31:0]       r_cas_fail_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_accept, w_access, w_in_range, w_cas_ok, w_cas_fail, w_we;
  logic [DATA_W-1:0] w_word_idx, w_mem_rd, w_rsp_next;
  logic [IDX_W-1:0]  w_idx;

  assign w_accept   = (r_state == StIdle) && mem_req_val_i;
  assign w_access   = (r_state == StBusy) && (r_cnt == 8'd0);
  assign w_word_idx = r_addr >> OFS;
  assign w_idx      = w_word_idx[IDX_W-1:0];
  assign w_in_range = w_word_idx < DATA_W'(DEPTH);
  assign w_mem_rd   = r_mem[w_idx];
  assign w_cas_ok   = w_in_range && (w_mem_rd == CAS_EXP);
  assign w_cas_fail = w_access && r_op_cas && !w_cas_ok;
  // CAS wins over store; out-of-range stores are silently dropped.
  assign w_we       = w_access && (r_op_cas ? w_cas_ok : (r_op_wr && w_in_range));

  always_comb begin
    w_rsp_next = '0;
    if (r_op_cas) begin
      w_rsp_next = w_cas_ok ? '0 : DATA_W'(1);
    end else if (!r_op_wr && w_in_range) begin
      w_rsp_next = w_mem_rd;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (mem_req_val_i) w_state_next = StBusy;
      StBusy: if (r_cnt == 8'd0) w_state_next = StResp;
      StResp: if (mem_rsp_rdy_i) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs decode registered state only.
  always_comb begin
    mem_req_rdy_o = 1'b0;
    mem_rsp_val_o = 1'b0;
    unique case (r_state)
      StIdle:  mem_req_rdy_o = 1'b1;
      StBusy:  ;
      StResp:  mem_rsp_val_o = 1'b1;
      default: ;
    endcase
  end

  assign mem_rsp_data_o = r_rsp_data;
  assign cas_fail_cnt_o = r_cas_fail_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt          <= 8'd0;
      r_op_cas       <= 1'b0;
      r_op_wr        <= 1'b0;
      r_addr         <= '0;
      r_data         <= '0;
      r_rsp_data     <= '0;
      r_cas_fail_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_cnt    <= 8'(LATENCY - 1);
        r_op_cas <= mem_req_is_cas_i;
        r_op_wr  <= mem_req_is_write_i;
        r_addr   <= mem_req_addr_i;
        r_data   <= mem_req_data_i;
      end else if (r_state == StBusy && r_cnt != 8'd0) begin
        r_cnt <= r_cnt - 8'd1;
      end
      if (w_access) begin
        r_rsp_data <= w_rsp_next;
      end
      if (w_cas_fail && r_cas_fail_cnt != 32'hFFFF_FFFF) begin
        r_cas_fail_cnt <= r_cas_fail_cnt + 32'd1;
      end
    end
  end

  // Array is deliberately not reset; the write is gated by state, so a reset
  // before the access edge suppresses it.
  always_ff @(posedge clk_i) begin
    if (w_we) begin
      r_mem[w_idx] <= r_data;
    end
  end

endmodule

// File: tb/tb_falafel_mem_responder.sv
// Scoreboard bench for falafel_mem_responder: a behavioural memory model predicts each
// response, which is queued at request time and compared when the response arrives.
module tb_falafel_mem_responder;

  localparam int unsigned LAT = 2;
  localparam logic [31:0] EXP_KEY = falafel_pkg::EMPTY_KEY;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        mem_req_val_i = 1'b0;
  logic        mem_req_rdy_o;
  logic        mem_req_is_write_i = 1'b0;
  logic        mem_req_is_cas_i = 1'b0;
  logic [31:0] mem_req_addr_i = '0;
  logic [31:0] mem_req_data_i = '0;
  logic        mem_rsp_val_o;
  logic        mem_rsp_rdy_i = 1'b0;
  logic [31:0] mem_rsp_data_o;
  logic [31:0] cas_fail_cnt_o;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mdl[int];
  logic [31:0] mdl_fail = '0;

  always #5 clk_i = ~clk_i;

  falafel_mem_responder #(
    .DATA_W (32),
    .DEPTH  (1024),
    .LATENCY(LAT),
    .CAS_EXP(EXP_KEY)
  ) u_dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .mem_req_val_i     (mem_req_val_i),
    .mem_req_rdy_o     (mem_req_rdy_o),
    .mem_req_is_write_i(mem_req_is_write_i),
    .mem_req_is_cas_i  (mem_req_is_cas_i),
    .mem_req_addr_i    (mem_req_addr_i),
    .mem_req_data_i    (mem_req_data_i),
    .mem_rsp_val_o     (mem_rsp_val_o),
    .mem_rsp_rdy_i     (mem_rsp_rdy_i),
    .mem_rsp_data_o    (mem_rsp_data_o),
    .cas_fail_cnt_o    (cas_fail_cnt_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_mdl(input int idx);
    return mdl.exists(idx) ? mdl[idx] : 32'h0;
  endfunction

  // Behavioural prediction of one request; updates model state.
  function automatic logic [31:0] predict(input logic cas, input logic wr,
                                          input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] idx = addr >> 2;
    bit          inr = (idx < 32'd1024);
    if (cas) begin
      if (inr && rd_mdl(int'(idx)) == EXP_KEY) begin
        mdl[int'(idx)] = data;
        return 32'h0;
      end
      if (mdl_fail != 32'hFFFF_FFFF) mdl_fail = mdl_fail + 1;
      return 32'h1;
    end
    if (wr) begin
      if (inr) mdl[int'(idx)] = data;
      return 32'h0;
    end
    return inr ? rd_mdl(int'(idx)) : 32'h0;
  endfunction

  task automatic xact(input logic cas, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input int bp);
    int          n;
    logic [31:0] held;
    logic [31:0] exp;
    exp_q.push_back(predict(cas, wr, addr, data));
    @(negedge clk_i);
    mem_req_val_i      = 1'b1;
    mem_req_is_cas_i   = cas;
    mem_req_is_write_i = wr;
    mem_req_addr_i     = addr;
    mem_req_data_i     = data;
    n = 0;
    while (!mem_req_rdy_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 50) check_eq("accept_timeout", 32'(n), 32'h0);
    @(posedge clk_i);
    #1;
    // Scramble request inputs; they must be ignored outside acceptance.
    mem_req_val_i      = 1'b0;
    mem_req_is_cas_i   = 1'($urandom);
    mem_req_is_write_i = 1'($urandom);
    mem_req_addr_i     = $urandom;
    mem_req_data_i     = $urandom;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!mem_rsp_val_o && n < 300);
    check_eq("rsp_latency", 32'(n), 32'(LAT + 1));
    held = mem_rsp_data_o;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk_i);
      check_eq("bp_val", {31'h0, mem_rsp_val_o}, 32'h1);
      check_eq("bp_data", mem_rsp_data_o, held);
      check_eq("bp_req_rdy", {31'h0, mem_req_rdy_o}, 32'h0);
    end
    mem_rsp_rdy_i = 1'b1;
    exp = exp_q.pop_front();
    check_eq("rsp_data", mem_rsp_data_o, exp);
    @(posedge clk_i);
    #1;
    mem_rsp_rdy_i = 1'b0;
    @(negedge clk_i);
    check_eq("req_rdy_after", {31'h0, mem_req_rdy_o}, 32'h1);
    check_eq("rsp_val_after", {31'h0, mem_rsp_val_o}, 32'h0);
    check_eq("cas_fail_cnt", cas_fail_cnt_o, mdl_fail);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_req_rdy", {31'h0, mem_req_rdy_o}, 32'h1);
    check_eq("rst_rsp_val", {31'h0, mem_rsp_val_o}, 32'h0);
    check_eq("rst_rsp_data", mem_rsp_data_o, 32'h0);
    check_eq("rst_cas_cnt", cas_fail_cnt_o, 32'h0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk_i);
    check_reset_outputs();
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Store then load, including a misaligned address.
    xact(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 0);
    xact(1'b0, 1'b0, 32'h40, 32'h0, 0);
    xact(1'b0, 1'b0, 32'h43, 32'h0, 0);

    // CAS success then failure.
    xact(1'b0, 1'b1, 32'h80, EXP_KEY, 0);
    xact(1'b1, 1'b0, 32'h80, 32'd5, 0);
    xact(1'b0, 1'b0, 32'h80, 32'h0, 0);
    xact(1'b1, 1'b0, 32'h80, 32'd6, 0);
    check_eq("cas_fail_one", cas_fail_cnt_o, 32'd1);
    xact(1'b0, 1'b0, 32'h80, 32'h0, 0);

    // CAS takes priority over write.
    xact(1'b0, 1'b1, 32'hC0, 32'd7, 0);
    xact(1'b1, 1'b1, 32'hC0, 32'd9, 0);
    xact(1'b0, 1'b0, 32'hC0, 32'h0, 0);

    // Backpressure on the response.
    xact(1'b0, 1'b0, 32'h40, 32'h0, 10);

    // Out of range: word index 1024.
    xact(1'b0, 1'b0, 32'h1000, 32'h0, 0);
    xact(1'b0, 1'b1, 32'h1000, 32'h1234, 0);
    xact(1'b0, 1'b0, 32'h0, 32'h0, 0);
    xact(1'b0, 1'b0, 32'h40, 32'h0, 0);
    xact(1'b1, 1'b0, 32'h1000, 32'h77, 0);

    // Mixed traffic over a small address window.
    for (int i = 0; i < 24; i++) begin
      xact(1'($urandom_range(0, 3) == 0), 1'($urandom), 32'($urandom_range(0, 15)) << 2,
           32'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    // Reset during BUSY, before the access edge.
    xact(1'b0, 1'b1, 32'h100, 32'd9, 0);
    @(negedge clk_i);
    mem_req_val_i      = 1'b1;
    mem_req_is_cas_i   = 1'b0;
    mem_req_is_write_i = 1'b1;
    mem_req_addr_i     = 32'h100;
    mem_req_data_i     = 32'h55;
    n = 0;
    while (!mem_req_rdy_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 50) check_eq("accept_timeout", 32'(n), 32'h0);
    @(posedge clk_i);
    #1;
    mem_req_val_i = 1'b0;
    rst_ni        = 1'b0;
    mdl_fail      = '0;
    @(negedge clk_i);
    check_reset_outputs();
    @(negedge clk_i);
    rst_ni = 1'b1;
    xact(1'b0, 1'b0, 32'h100, 32'h0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
